// File: rtl/mux_scan_capture.sv
// mux_scan_capture: steps a 4:1 mux select, samples y after a settle time per channel,
// and delivers the 4-bit word through a one-entry valid/ready output register.
module mux_scan_capture #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       y,
  input  logic       out_ready,
  output logic [1:0] s,
  output logic       busy,
  output logic [3:0] word,
  output logic       word_valid
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
  state_t     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] word_q, word_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       ld_try;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      s_q      <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 4'd0;
      word_q   <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    valid_d  = valid_q && !out_ready;
    busy_d   = busy_q;
    ld_try   = 1'b0;
    case (state_q)
      ST_IDLE:
        if (start) begin
          state_d = ST_SETTLE;
          s_d     = 2'd0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
        end
      ST_SETTLE:
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else begin
          shadow_d[s_q] = y;
          if (s_q != 2'd3) begin
            s_d   = s_q + 2'd1;
            cnt_d = CNT_INIT;
          end else ld_try = 1'b1;
        end
      ST_HOLD: ld_try = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    // a consume and a new load may share an edge, keeping word_valid high
    if (ld_try) begin
      if (!valid_q || out_ready) begin
        word_d  = shadow_d;
        valid_d = 1'b1;
        busy_d  = cont;
        state_d = cont ? ST_SETTLE : ST_IDLE;
        s_d     = 2'd0;
        cnt_d   = CNT_INIT;
      end else state_d = ST_HOLD;
    end
  end
  assign s          = s_q;
  assign busy       = busy_q;
  assign word       = word_q;
  assign word_valid = valid_q;
endmodule

// File: tb/tb_mux_scan_capture.sv
// tb_mux_scan_capture: directed checks of two scan controllers (SETTLE=1 and SETTLE=3)
// each driving a bench 4:1 mux built from a 4-bit input vector.
module tb_mux_scan_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start1 = 1'b0, cont1 = 1'b0, rdy1 = 1'b1, start3 = 1'b0, rdy3 = 1'b1;
  logic [3:0] i1 = 4'd0, i3 = 4'd0;
  logic [1:0] s1, s3;
  logic busy1, busy3, v1, v3, y1, y3;
  logic [3:0] w1, w3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign y1 = i1[s1];
  assign y3 = i3[s3];

  mux_scan_capture #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .y(y1), .out_ready(rdy1),
    .s(s1), .busy(busy1), .word(w1), .word_valid(v1));
  mux_scan_capture #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cont(1'b0), .y(y3), .out_ready(rdy3),
    .s(s3), .busy(busy3), .word(w3), .word_valid(v3));

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scan1(input logic [3:0] v, input string tag);
    i1 = v;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    chk({tag, "_word"}, w1, v);
    chk({tag, "_valid"}, {3'd0, v1}, 4'd1);
    tick();
    chk({tag, "_drain"}, {3'd0, v1}, 4'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_s", {2'd0, s1}, 4'd0);
    chk("rst_word", w1, 4'd0);
    chk("rst_valid", {3'd0, v1}, 4'd0);
    chk("rst_busy", {3'd0, busy1}, 4'd0);
    #20 rst_n = 1'b1;
    tick();

    // single scan, SETTLE=1
    i1 = 4'b1010;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_s", {2'd0, s1}, 4'(k));
      chk("t1_busy", {3'd0, busy1}, 4'd1);
      chk("t1_valid_low", {3'd0, v1}, 4'd0);
      tick();
    end
    chk("t1_word", w1, 4'b1010);
    chk("t1_valid", {3'd0, v1}, 4'd1);
    chk("t1_busy_low", {3'd0, busy1}, 4'd0);
    chk("t1_s_idle", {2'd0, s1}, 4'd0);
    tick();
    chk("t1_consumed", {3'd0, v1}, 4'd0);

    // settle timing, SETTLE=3
    i3 = 4'b0110;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 3; j++) begin
        chk("t2_s", {2'd0, s3}, 4'(k));
        chk("t2_valid_low", {3'd0, v3}, 4'd0);
        tick();
      end
    chk("t2_word", w3, 4'b0110);
    chk("t2_valid", {3'd0, v3}, 4'd1);
    chk("t2_busy_low", {3'd0, busy3}, 4'd0);

    // backpressure in continuous mode
    rdy1 = 1'b0;
    cont1 = 1'b1;
    i1 = 4'b0001;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    chk("t3_word1", w1, 4'b0001);
    chk("t3_valid1", {3'd0, v1}, 4'd1);
    chk("t3_restart_s", {2'd0, s1}, 4'd0);
    chk("t3_restart_busy", {3'd0, busy1}, 4'd1);
    i1 = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t3_word_hold", w1, 4'b0001);
      chk("t3_valid_hold", {3'd0, v1}, 4'd1);
    end
    chk("t3_hold_s", {2'd0, s1}, 4'd3);
    chk("t3_hold_busy", {3'd0, busy1}, 4'd1);
    tick();
    chk("t3_hold_s2", {2'd0, s1}, 4'd3);
    rdy1 = 1'b1;
    tick();
    chk("t3_word2", w1, 4'b1000);
    chk("t3_valid2", {3'd0, v1}, 4'd1);
    chk("t3_rescan_s", {2'd0, s1}, 4'd0);
    chk("t3_rescan_busy", {3'd0, busy1}, 4'd1);
    cont1 = 1'b0;
    tick();
    chk("t3_consumed", {3'd0, v1}, 4'd0);
    chk("t3_s1", {2'd0, s1}, 4'd1);
    repeat (3) tick();
    chk("t3_word3", w1, 4'b1000);
    chk("t3_valid3", {3'd0, v1}, 4'd1);
    chk("t3_idle_busy", {3'd0, busy1}, 4'd0);
    tick();
    chk("t3_drain", {3'd0, v1}, 4'd0);

    // start ignored while busy
    i1 = 4'b0101;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("t4_s1", {2'd0, s1}, 4'd1);
    start1 = 1'b1;
    tick();
    chk("t4_s2", {2'd0, s1}, 4'd2);
    tick();
    start1 = 1'b0;
    chk("t4_s3", {2'd0, s1}, 4'd3);
    tick();
    chk("t4_word", w1, 4'b0101);
    chk("t4_valid", {3'd0, v1}, 4'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_no_second", {3'd0, v1}, 4'd0);
      chk("t4_idle_busy", {3'd0, busy1}, 4'd0);
      chk("t4_idle_s", {2'd0, s1}, 4'd0);
    end

    // asynchronous reset mid-scan
    i1 = 4'b0110;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (2) tick();
    chk("t5_s_pre", {2'd0, s1}, 4'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_s", {2'd0, s1}, 4'd0);
    chk("t5_rst_word", w1, 4'd0);
    chk("t5_rst_valid", {3'd0, v1}, 4'd0);
    chk("t5_rst_busy", {3'd0, busy1}, 4'd0);
    tick();
    chk("t5_rst_held", {2'd0, s1}, 4'd0);
    #2 rst_n = 1'b1;
    tick();
    scan1(4'b1111, "t5");

    // all-zero / all-one channels
    scan1(4'b0000, "t6_zero");
    scan1(4'b1111, "t6_one");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
